// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
//   Sequences the control-flow redirect that follows branch resolution in EX.
//   Computes the branch/jump target from pc_sel {b_jal, jalr}. It presents the
//   target to fetch with a valid/ready handshake, flushes wrong-path IF/ID/EX
//   contents and stalls EX until fetch accepts. After acceptance it keeps
//   flushing IF/ID for FLUSH_CYCLES more cycles. A saturating counter tracks
//   how many redirects fetch accepted.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   ex_valid        EX holds a valid instruction
//   pc_sel          {b_jal, jalr} from branch resolution
//   ex_pc/ex_imm    PC and sign-extended immediate of the EX instruction
//   ex_rs1          jalr base operand
//   fetch_ready     fetch accepts the redirect this cycle
//   redirect_valid  redirect_pc valid, held until accepted
//   redirect_pc     new fetch address
//   flush_if_id     kill IF/ID contents
//   flush_id_ex     kill ID/EX contents (one-cycle pulse)
//   ex_stall        hold EX/downstream issue
//   busy            controller not idle
//   taken_cnt       accepted redirects, saturating
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter int ADDR_WIDTH   = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [1:0]            pc_sel,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [ADDR_WIDTH-1:0] ex_imm,
    input  logic [ADDR_WIDTH-1:0] ex_rs1,
    input  logic                  fetch_ready,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  ex_stall,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  taken_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0]            FLUSH_LOAD = FLUSH_CYCLES[3:0];
    localparam bit                    HAS_FLUSH  = (FLUSH_CYCLES != 0);
    // jalr targets have bit 0 forced to zero
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   target_s;
    logic                    trigger_s;
    logic                    accept_s;
    logic [3:0]              flush_cnt_r;
    logic [CNT_WIDTH-1:0]    taken_cnt_r;
    logic [ADDR_WIDTH-1:0]   redirect_pc_r;

    logic                    redirect_valid_r, redirect_valid_nxt_s;
    logic                    flush_if_id_r,    flush_if_id_nxt_s;
    logic                    flush_id_ex_r,    flush_id_ex_nxt_s;
    logic                    ex_stall_r,       ex_stall_nxt_s;
    logic                    busy_r,           busy_nxt_s;

    // Triggers are only honoured in IDLE; anything arriving later is wrong-path.
    assign trigger_s = ex_valid & (|pc_sel) & (state_r == IDLE);
    // redirect_valid is high exactly while in REDIR, so acceptance is keyed on state.
    assign accept_s  = (state_r == REDIR) & fetch_ready;

    // Target selection: jalr has priority when both select bits are set.
    always_comb begin
        target_s = '0;
        case (pc_sel)
            2'b10:        target_s = ex_pc + ex_imm;
            2'b01, 2'b11: target_s = (ex_rs1 + ex_imm) & ALIGN_MASK;
            default:      target_s = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (trigger_s) state_nxt_s = REDIR;
                else           state_nxt_s = IDLE;
            end
            REDIR: begin
                if (fetch_ready) state_nxt_s = HAS_FLUSH ? FLUSH : IDLE;
                else             state_nxt_s = REDIR;
            end
            FLUSH: begin
                if (flush_cnt_r == 4'd1) state_nxt_s = IDLE;
                else                     state_nxt_s = FLUSH;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the next state, so every output leaves a flop.
    always_comb begin
        redirect_valid_nxt_s = 1'b0;
        flush_if_id_nxt_s    = 1'b0;
        ex_stall_nxt_s       = 1'b0;
        case (state_nxt_s)
            REDIR: begin
                redirect_valid_nxt_s = 1'b1;
                flush_if_id_nxt_s    = 1'b1;
                ex_stall_nxt_s       = 1'b1;
            end
            FLUSH:   flush_if_id_nxt_s = 1'b1;
            IDLE:    flush_if_id_nxt_s = 1'b0;
            default: flush_if_id_nxt_s = 1'b0;
        endcase
        // Only the IDLE->REDIR entry produces the ID/EX kill pulse.
        flush_id_ex_nxt_s = trigger_s;
        busy_nxt_s        = (state_nxt_s != IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_r <= 1'b0;
            flush_if_id_r    <= 1'b0;
            flush_id_ex_r    <= 1'b0;
            ex_stall_r       <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            redirect_valid_r <= redirect_valid_nxt_s;
            flush_if_id_r    <= flush_if_id_nxt_s;
            flush_id_ex_r    <= flush_id_ex_nxt_s;
            ex_stall_r       <= ex_stall_nxt_s;
            busy_r           <= busy_nxt_s;
        end
    end

    // Redirect target: captured on trigger, held stable until the next trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc_r <= '0;
        end else if (trigger_s) begin
            redirect_pc_r <= target_s;
        end else begin
            redirect_pc_r <= redirect_pc_r;
        end
    end

    // Post-accept flush countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= 4'd0;
        end else if (accept_s) begin
            flush_cnt_r <= FLUSH_LOAD;
        end else if ((state_r == FLUSH) && (flush_cnt_r != 4'd0)) begin
            flush_cnt_r <= flush_cnt_r - 4'd1;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Saturating count of accepted redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_r <= '0;
        end else if (accept_s && (taken_cnt_r != {CNT_WIDTH{1'b1}})) begin
            taken_cnt_r <= taken_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            taken_cnt_r <= taken_cnt_r;
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign flush_if_id    = flush_if_id_r;
    assign flush_id_ex    = flush_id_ex_r;
    assign ex_stall       = ex_stall_r;
    assign busy           = busy_r;
    assign taken_cnt      = taken_cnt_r;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Instance 1: default build (FLUSH_CYCLES=2, CNT_WIDTH=32)
    logic        ex_valid = 1'b0, fetch_ready = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [63:0] ex_pc = '0, ex_imm = '0, ex_rs1 = '0;
    logic        redirect_valid, flush_if_id, flush_id_ex, ex_stall, busy;
    logic [63:0] redirect_pc;
    logic [31:0] taken_cnt;

    // Instance 2: FLUSH_CYCLES=0, CNT_WIDTH=4
    logic        v2 = 1'b0, fr2 = 1'b0;
    logic [1:0]  sel2 = 2'b00;
    logic [63:0] pc2 = '0, imm2 = '0, rs12 = '0;
    logic        rv2, fii2, fie2, st2, busy2;
    logic [63:0] rpc2;
    logic [3:0]  cnt2;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_pc;
    int exp_cnt1 = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.ADDR_WIDTH(64), .FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .pc_sel(pc_sel),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .ex_stall(ex_stall),
        .busy(busy), .taken_cnt(taken_cnt)
    );

    branch_redirect_ctrl #(.ADDR_WIDTH(64), .FLUSH_CYCLES(0), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .ex_valid(v2), .pc_sel(sel2),
        .ex_pc(pc2), .ex_imm(imm2), .ex_rs1(rs12), .fetch_ready(fr2),
        .redirect_valid(rv2), .redirect_pc(rpc2),
        .flush_if_id(fii2), .flush_id_ex(fie2), .ex_stall(st2),
        .busy(busy2), .taken_cnt(cnt2)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic        trig;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pop_exp();
        logic [63:0] r;
        if (sb_q.size() > 0) r = sb_q.pop_front();
        else                 r = 'x;
        return r;
    endfunction

    initial begin
        vecs[0] = '{1'b1, 2'b10, 64'h1000, 64'h20, 64'h0, 1'b1, 64'h1020};
        vecs[1] = '{1'b1, 2'b01, 64'h1000, 64'h4, 64'h2003, 1'b1, 64'h2006};
        vecs[2] = '{1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 1'b1, 64'h10};
        vecs[3] = '{1'b1, 2'b11, 64'h100, 64'h10, 64'h3001, 1'b1, 64'h3010};
        vecs[4] = '{1'b1, 2'b10, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b1, 64'hFF8};
        vecs[5] = '{1'b1, 2'b00, 64'h1000, 64'h20, 64'h0, 1'b0, 64'h0};
        vecs[6] = '{1'b0, 2'b10, 64'h1000, 64'h20, 64'h0, 1'b0, 64'h0};

        // Reset state
        #3;
        chk("rst_rv", 64'(redirect_valid), 64'd0);
        chk("rst_pc", redirect_pc, 64'd0);
        chk("rst_fii", 64'(flush_if_id), 64'd0);
        chk("rst_fie", 64'(flush_id_ex), 64'd0);
        chk("rst_stall", 64'(ex_stall), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(taken_cnt), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Table-driven vectors, fetch always ready
        for (int i = 0; i < 7; i++) begin
            ex_valid = vecs[i].v; pc_sel = vecs[i].sel; ex_pc = vecs[i].pc;
            ex_imm = vecs[i].imm; ex_rs1 = vecs[i].rs1; fetch_ready = 1'b1;
            if (vecs[i].trig) sb_q.push_back(vecs[i].exp_pc);
            step();
            ex_valid = 1'b0;
            if (vecs[i].trig) begin
                exp_pc = pop_exp();
                chk($sformatf("v%0d_rv", i), 64'(redirect_valid), 64'd1);
                chk($sformatf("v%0d_pc", i), redirect_pc, exp_pc);
                chk($sformatf("v%0d_fie", i), 64'(flush_id_ex), 64'd1);
                chk($sformatf("v%0d_stall", i), 64'(ex_stall), 64'd1);
                step();
                exp_cnt1++;
                chk($sformatf("v%0d_f1_rv", i), 64'(redirect_valid), 64'd0);
                chk($sformatf("v%0d_f1_fie", i), 64'(flush_id_ex), 64'd0);
                chk($sformatf("v%0d_f1_fii", i), 64'(flush_if_id), 64'd1);
                chk($sformatf("v%0d_f1_stall", i), 64'(ex_stall), 64'd0);
                chk($sformatf("v%0d_cnt", i), 64'(taken_cnt), 64'(exp_cnt1));
                step();
                chk($sformatf("v%0d_f2_fii", i), 64'(flush_if_id), 64'd1);
                chk($sformatf("v%0d_f2_busy", i), 64'(busy), 64'd1);
                step();
                chk($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
                chk($sformatf("v%0d_idle_fii", i), 64'(flush_if_id), 64'd0);
            end else begin
                chk($sformatf("v%0d_noact_busy", i), 64'(busy), 64'd0);
                chk($sformatf("v%0d_noact_rv", i), 64'(redirect_valid), 64'd0);
                chk($sformatf("v%0d_noact_cnt", i), 64'(taken_cnt), 64'(exp_cnt1));
            end
        end

        // Backpressure: fetch not ready for 5 REDIR cycles, accepts on the 6th
        ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h4000; ex_imm = 64'h100; fetch_ready = 1'b0;
        sb_q.push_back(64'h4100);
        step();
        ex_valid = 1'b0;
        exp_pc = pop_exp();
        for (int k = 0; k < 6; k++) begin
            fetch_ready = (k == 5);
            chk($sformatf("bp%0d_rv", k), 64'(redirect_valid), 64'd1);
            chk($sformatf("bp%0d_pc", k), redirect_pc, exp_pc);
            chk($sformatf("bp%0d_stall", k), 64'(ex_stall), 64'd1);
            chk($sformatf("bp%0d_fii", k), 64'(flush_if_id), 64'd1);
            chk($sformatf("bp%0d_fie", k), 64'(flush_id_ex), (k == 0) ? 64'd1 : 64'd0);
            chk($sformatf("bp%0d_cnt", k), 64'(taken_cnt), 64'(exp_cnt1));
            step();
        end
        exp_cnt1++;
        chk("bp_acc_rv", 64'(redirect_valid), 64'd0);
        chk("bp_acc_cnt", 64'(taken_cnt), 64'(exp_cnt1));
        step(); step();
        chk("bp_idle", 64'(busy), 64'd0);
        chk("bp_cnt_once", 64'(taken_cnt), 64'(exp_cnt1));

        // Shadow branch held active throughout REDIR and FLUSH
        ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h5000; ex_imm = 64'h10; fetch_ready = 1'b0;
        sb_q.push_back(64'h5010);
        step();
        exp_pc = pop_exp();
        ex_imm = 64'h40;
        chk("sh_pc0", redirect_pc, exp_pc);
        step();
        chk("sh_pc1", redirect_pc, exp_pc);
        fetch_ready = 1'b1;
        step();
        exp_cnt1++;
        chk("sh_flush_pc", redirect_pc, exp_pc);
        step(); step();
        chk("sh_idle_busy", 64'(busy), 64'd0);
        chk("sh_idle_rv", 64'(redirect_valid), 64'd0);
        ex_valid = 1'b0;
        step();
        chk("sh_stay_idle", 64'(busy), 64'd0);
        chk("sh_pc_final", redirect_pc, exp_pc);
        chk("sh_cnt", 64'(taken_cnt), 64'(exp_cnt1));

        // Async reset in the middle of REDIR with fetch stalled
        ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h6000; ex_imm = 64'h8; fetch_ready = 1'b0;
        sb_q.push_back(64'h6008);
        step();
        ex_valid = 1'b0;
        chk("ar_rv_pre", 64'(redirect_valid), 64'd1);
        chk("ar_pc_pre", redirect_pc, pop_exp());
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rv", 64'(redirect_valid), 64'd0);
        chk("ar_pc", redirect_pc, 64'd0);
        chk("ar_fii", 64'(flush_if_id), 64'd0);
        chk("ar_fie", 64'(flush_id_ex), 64'd0);
        chk("ar_stall", 64'(ex_stall), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_cnt", 64'(taken_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt1 = 0;
        fetch_ready = 1'b1;
        step(); step(); step();
        chk("ar_post_busy", 64'(busy), 64'd0);
        chk("ar_post_rv", 64'(redirect_valid), 64'd0);
        chk("ar_post_cnt", 64'(taken_cnt), 64'd0);

        // FLUSH_CYCLES=0 build: idle right after accept; 4-bit counter saturates
        fr2 = 1'b1; sel2 = 2'b10; imm2 = 64'h4;
        for (int i = 0; i < 18; i++) begin
            v2 = 1'b1; pc2 = 64'(i) << 8;
            sb_q.push_back((64'(i) << 8) + 64'h4);
            step();
            v2 = 1'b0;
            chk($sformatf("z%0d_rv", i), 64'(rv2), 64'd1);
            chk($sformatf("z%0d_pc", i), rpc2, pop_exp());
            step();
            chk($sformatf("z%0d_idle", i), 64'(busy2), 64'd0);
            chk($sformatf("z%0d_fii", i), 64'(fii2), 64'd0);
            chk($sformatf("z%0d_cnt", i), 64'(cnt2), (i + 1 > 15) ? 64'd15 : 64'(i + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
